// File: rtl/uart_rx_packer.sv
// 8N1 UART receiver that packs four consecutive bytes (first byte in [31:24])
// into a word presented on a one-deep valid/ready output register.
module uart_rx_packer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] Tx_data,
  output logic        Tx_valid,
  input  logic        Tx_ready,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic          sync1, rxs;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sr;
  logic [1:0]    byte_count;
  logic [23:0]   part;
  logic [TW-1:0] to_cnt;

  logic expiry, good_stop, bad_stop, word_done, accept;

  assign expiry    = (cnt == '0);
  assign good_stop = (state == S_STOP) && expiry && rxs;
  assign bad_stop  = (state == S_STOP) && expiry && !rxs;
  assign word_done = good_stop && (byte_count == 2'd3);
  assign accept    = !Tx_valid || Tx_ready;
  assign busy      = (state != S_IDLE) || (byte_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rxs   <= sync1;
    end
  end

  // Bit-timing FSM: counter reloads at each sample point, mid-bit after START.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sr      <= '0;
    end else begin
      case (state)
        S_IDLE: if (!rxs) begin
          cnt   <= HALF_M1;
          state <= S_START;
        end
        S_START: if (expiry) begin
          if (!rxs) begin
            cnt     <= FULL_M1;
            bit_idx <= '0;
            state   <= S_DATA;
          end else begin
            state <= S_IDLE;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_DATA: if (expiry) begin
          sr  <= {rxs, sr[7:1]};
          cnt <= FULL_M1;
          if (bit_idx == 3'd7) state <= S_STOP;
          bit_idx <= bit_idx + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_STOP: if (expiry) begin
          state <= rxs ? S_IDLE : S_WAIT_HIGH;
        end else begin
          cnt <= cnt - 1'b1;
        end
        S_WAIT_HIGH: if (rxs) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte packing and idle timeout; timeout only runs while a partial word is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count <= '0;
      part       <= '0;
      to_cnt     <= '0;
    end else begin
      if (good_stop) begin
        case (byte_count)
          2'd0:    part[23:16] <= sr;
          2'd1:    part[15:8]  <= sr;
          2'd2:    part[7:0]   <= sr;
          default: ;
        endcase
        byte_count <= byte_count + 2'd1;
        to_cnt     <= TW'(1);
      end else if (bad_stop) begin
        byte_count <= '0;
      end else if (state != S_IDLE) begin
        to_cnt <= '0;
      end else if (byte_count != 2'd0) begin
        if (to_cnt == TO_LAST) begin
          byte_count <= '0;
          to_cnt     <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Tx_data   <= '0;
      Tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= word_done && !accept;
      if (word_done && accept) begin
        Tx_data  <= {part, sr};
        Tx_valid <= 1'b1;
      end else if (Tx_valid && Tx_ready) begin
        Tx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Bench for uart_rx_packer: serial stimulus, word-level reference model and
// a monitor that logs handshakes, pulses and output stability.
module tb_uart_rx_packer;
  localparam int CPB = 8;
  localparam int TOB = 20;

  logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, Tx_ready = 1'b0;
  logic [31:0] Tx_data;
  logic Tx_valid, frame_err, overrun, busy;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  uart_rx_packer #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .Tx_data(Tx_data), .Tx_valid(Tx_valid),
    .Tx_ready(Tx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  // Monitor: only this process writes these.
  logic [31:0] got_q[$];
  int fe_cnt = 0, ov_cnt = 0, vc = 0, stab = 0;
  logic pv = 1'b0, phs = 1'b0;
  logic [31:0] pd = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv = 1'b0; phs = 1'b0;
    end else begin
      if (pv && !phs && (!Tx_valid || Tx_data !== pd)) stab++;
      if (Tx_valid && Tx_ready) got_q.push_back(Tx_data);
      if (Tx_valid) vc++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      pv = Tx_valid; pd = Tx_data; phs = Tx_valid && Tx_ready;
    end
  end

  // Reference model: four good bytes in a row form a word, first byte on top.
  logic [31:0] exp_q[$];
  int m_n = 0;
  logic [31:0] m_acc = '0;

  task automatic m_byte(input logic [7:0] b);
    m_acc = {m_acc[23:0], b};
    m_n++;
    if (m_n == 4) begin
      exp_q.push_back(m_acc);
      m_n = 0;
    end
  endtask

  task automatic m_drop();
    m_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stop_ok;
    repeat (CPB) tick();
    uart_rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++; if (Tx_data !== 32'h0) begin n_err++; $display("FAIL reset_data got %h want 0", Tx_data); end
    n_cmp++; if (Tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", Tx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_ovr got %b want 0", overrun); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word();
    int gb, eb, fb, ob, vb;
    logic [7:0] bytes [4];
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    gb = got_q.size(); eb = exp_q.size(); fb = fe_cnt; ob = ov_cnt; vb = vc;
    Tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin send_byte(bytes[i], 1'b1); m_byte(bytes[i]); end
    repeat (10) tick();
    n_cmp++; if (got_q.size() - gb != 1) begin n_err++; $display("FAIL word_count got %0d want 1", got_q.size() - gb); end
    n_cmp++; if (got_q.size() > gb && got_q[gb] !== exp_q[eb]) begin n_err++; $display("FAIL word_data got %h want %h", got_q[gb], exp_q[eb]); end
    n_cmp++; if (vc - vb != 1) begin n_err++; $display("FAIL word_valid_cycles got %0d want 1", vc - vb); end
    n_cmp++; if (fe_cnt != fb || ov_cnt != ob) begin n_err++; $display("FAIL word_pulses got fe %0d ov %0d want 0 0", fe_cnt - fb, ov_cnt - ob); end
  endtask

  task automatic test_backpressure();
    int gb, eb, ob, sb;
    logic [31:0] dropped;
    gb = got_q.size(); eb = exp_q.size(); ob = ov_cnt; sb = stab;
    Tx_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k), 1'b1); m_byte(8'(k));
      if (k == 7) begin
        n_cmp++; if (ov_cnt != ob) begin n_err++; $display("FAIL bp_early_overrun got %0d want 0", ov_cnt - ob); end
      end
    end
    repeat (5) tick();
    // One-deep output with ready low: the second word has nowhere to go.
    dropped = exp_q.pop_back();
    n_cmp++; if (Tx_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid got %b want 1", Tx_valid); end
    n_cmp++; if (Tx_data !== exp_q[eb]) begin n_err++; $display("FAIL bp_data got %h want %h (dropped %h)", Tx_data, exp_q[eb], dropped); end
    n_cmp++; if (ov_cnt - ob != 1) begin n_err++; $display("FAIL bp_overrun got %0d want 1", ov_cnt - ob); end
    n_cmp++; if (stab != sb) begin n_err++; $display("FAIL bp_stable got %0d changes want 0", stab - sb); end
    n_cmp++; if (got_q.size() != gb) begin n_err++; $display("FAIL bp_no_hs got %0d want 0", got_q.size() - gb); end
    Tx_ready = 1'b1; tick(); Tx_ready = 1'b0;
    repeat (3) tick();
    n_cmp++; if (got_q.size() - gb != 1) begin n_err++; $display("FAIL bp_hs_count got %0d want 1", got_q.size() - gb); end
    n_cmp++; if (got_q.size() > gb && got_q[gb] !== exp_q[eb]) begin n_err++; $display("FAIL bp_hs_data got %h want %h", got_q[gb], exp_q[eb]); end
    n_cmp++; if (Tx_valid !== 1'b0) begin n_err++; $display("FAIL bp_after_hs_valid got %b want 0", Tx_valid); end
  endtask

  task automatic test_coincide();
    int gb, eb, ob;
    logic [7:0] b;
    gb = got_q.size(); eb = exp_q.size(); ob = ov_cnt;
    Tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin b = 8'($urandom); send_byte(b, 1'b1); m_byte(b); end
    b = 8'($urandom);
    // Stop sample of this byte lands 78 ticks after its start bit is driven.
    fork
      send_byte(b, 1'b1);
      begin repeat (78) tick(); Tx_ready = 1'b1; tick(); Tx_ready = 1'b0; end
    join
    m_byte(b);
    repeat (5) tick();
    n_cmp++; if (ov_cnt != ob) begin n_err++; $display("FAIL co_overrun got %0d want 0", ov_cnt - ob); end
    n_cmp++; if (Tx_valid !== 1'b1) begin n_err++; $display("FAIL co_valid got %b want 1", Tx_valid); end
    n_cmp++; if (Tx_data !== exp_q[eb+1]) begin n_err++; $display("FAIL co_data got %h want %h", Tx_data, exp_q[eb+1]); end
    n_cmp++; if (got_q.size() - gb != 1 || got_q[gb] !== exp_q[eb]) begin n_err++; $display("FAIL co_first_hs got n=%0d want %h", got_q.size() - gb, exp_q[eb]); end
    Tx_ready = 1'b1; tick(); Tx_ready = 1'b0;
    repeat (2) tick();
    n_cmp++; if (got_q.size() - gb != 2 || got_q[gb+1] !== exp_q[eb+1]) begin n_err++; $display("FAIL co_second_hs got n=%0d want %h", got_q.size() - gb, exp_q[eb+1]); end
  endtask

  task automatic test_frame_err();
    int gb, eb, fb, ob;
    logic [7:0] bytes [4];
    bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    gb = got_q.size(); eb = exp_q.size(); fb = fe_cnt; ob = ov_cnt;
    Tx_ready = 1'b1;
    send_byte(8'h11, 1'b1); m_byte(8'h11);
    send_byte(8'h22, 1'b0); m_drop();
    repeat (12) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL fe_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin send_byte(bytes[i], 1'b1); m_byte(bytes[i]); end
    repeat (10) tick();
    n_cmp++; if (fe_cnt - fb != 1) begin n_err++; $display("FAIL fe_pulses got %0d want 1", fe_cnt - fb); end
    n_cmp++; if (ov_cnt != ob) begin n_err++; $display("FAIL fe_overrun got %0d want 0", ov_cnt - ob); end
    n_cmp++; if (got_q.size() - gb != 1 || exp_q.size() - eb != 1) begin n_err++; $display("FAIL fe_word_count got %0d want %0d", got_q.size() - gb, exp_q.size() - eb); end
    else begin
      n_cmp++; if (got_q[gb] !== exp_q[eb]) begin n_err++; $display("FAIL fe_word got %h want %h", got_q[gb], exp_q[eb]); end
    end
  endtask

  task automatic test_glitch_timeout();
    int gb, eb;
    logic [7:0] bytes [4];
    bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
    gb = got_q.size(); eb = exp_q.size();
    Tx_ready = 1'b1;
    uart_rx = 1'b0; repeat (2) tick(); uart_rx = 1'b1;
    repeat (20) tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy got %b want 0", busy); end
    send_byte(8'h55, 1'b1); m_byte(8'h55);
    tick();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL partial_busy got %b want 1", busy); end
    repeat (170) tick();
    m_drop();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL timeout_busy got %b want 0", busy); end
    for (int i = 0; i < 4; i++) begin send_byte(bytes[i], 1'b1); m_byte(bytes[i]); end
    repeat (10) tick();
    n_cmp++; if (got_q.size() - gb != exp_q.size() - eb) begin n_err++; $display("FAIL to_word_count got %0d want %0d", got_q.size() - gb, exp_q.size() - eb); end
    else for (int i = 0; i < exp_q.size() - eb; i++) begin
      n_cmp++; if (got_q[gb+i] !== exp_q[eb+i]) begin n_err++; $display("FAIL to_word got %h want %h", got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_random_words();
    int gb, eb;
    logic [7:0] b;
    gb = got_q.size(); eb = exp_q.size();
    Tx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom); send_byte(b, 1'b1); m_byte(b);
      repeat ($urandom_range(0, 20)) tick();
    end
    repeat (10) tick();
    n_cmp++; if (got_q.size() - gb != exp_q.size() - eb) begin n_err++; $display("FAIL rnd_word_count got %0d want %0d", got_q.size() - gb, exp_q.size() - eb); end
    else for (int i = 0; i < exp_q.size() - eb; i++) begin
      n_cmp++; if (got_q[gb+i] !== exp_q[eb+i]) begin n_err++; $display("FAIL rnd_word got %h want %h", got_q[gb+i], exp_q[eb+i]); end
    end
  endtask

  task automatic test_reset_mid();
    int gb, eb;
    logic [7:0] b;
    logic [7:0] bytes [4];
    bytes = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    gb = got_q.size(); eb = exp_q.size();
    Tx_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin b = 8'($urandom); send_byte(b, 1'b1); m_byte(b); end
    // Bits sent after the reset are all 1 so no false start follows it.
    b = {6'h3F, 2'($urandom)};
    fork
      send_byte(b, 1'b1);
      begin
        repeat (30) tick();
        rst = 1'b1; tick();
        n_cmp++; if (Tx_data !== 32'h0) begin n_err++; $display("FAIL mid_rst_data got %h want 0", Tx_data); end
        n_cmp++; if (Tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b want 0", Tx_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_cmp++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL mid_rst_pulses got %b%b want 00", frame_err, overrun); end
        rst = 1'b0;
      end
    join
    m_drop();
    repeat (10) tick();
    for (int i = 0; i < 4; i++) begin send_byte(bytes[i], 1'b1); m_byte(bytes[i]); end
    repeat (10) tick();
    n_cmp++; if (got_q.size() - gb != 1 || exp_q.size() - eb != 1) begin n_err++; $display("FAIL mid_word_count got %0d want %0d", got_q.size() - gb, exp_q.size() - eb); end
    else begin
      n_cmp++; if (got_q[gb] !== exp_q[eb]) begin n_err++; $display("FAIL mid_word got %h want %h", got_q[gb], exp_q[eb]); end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_word();
    test_backpressure();
    test_coincide();
    test_frame_err();
    test_glitch_timeout();
    test_random_words();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
